// File: rtl/surf_id_pkg.sv
// Shared definitions for the SURF ID/control space.
// Holds the default device-DNA length, the Wishbone word indices of the
// DNA readout block, the control/status bit positions, and the encoding of
// the DNA readout sequencer states.
package surf_id_pkg;

  localparam int unsigned DNA_BITS_DEFAULT = 96;

  // Word indices selected by wb_adr_i[3:2].
  localparam logic [1:0] DNA_W0   = 2'd0;
  localparam logic [1:0] DNA_W1   = 2'd1;
  localparam logic [1:0] DNA_W2   = 2'd2;
  localparam logic [1:0] DNA_CTRL = 2'd3;

  // Bit positions inside the control/status word.
  localparam int unsigned CTRL_BUSY    = 0;
  localparam int unsigned CTRL_VALID   = 1;
  localparam int unsigned CTRL_RESTART = 31;

  // Sequencer states.
  typedef logic [1:0] dna_state_t;
  localparam dna_state_t IDLE  = 2'd0;
  localparam dna_state_t READ  = 2'd1;
  localparam dna_state_t SHIFT = 2'd2;
  localparam dna_state_t DONE  = 2'd3;

endpackage

// File: rtl/surf_dna_wb_regs.sv
// Wishbone slave for the DNA readout block.
// Decodes the four-word register window, generates a registered one-cycle
// ack, registers the readback data alongside it, and turns a write of the
// restart bit in the control word into a single-cycle restart request.
// Ports:
//   wb_clk_i, wb_rst_i   Wishbone clock and synchronous active-high reset
//   wb_cyc_i..wb_sel_i   Wishbone request
//   wb_ack_o, wb_dat_o   registered ack and read data
//   dna_i                captured DNA holding register
//   valid_i, busy_i      sequencer status
//   restart_o            restart request (combinational, one cycle per write)
module surf_dna_wb_regs
  import surf_id_pkg::*;
#(
  parameter int unsigned DNA_BITS = DNA_BITS_DEFAULT
) (
  input  logic                wb_clk_i,
  input  logic                wb_rst_i,
  input  logic                wb_cyc_i,
  input  logic                wb_stb_i,
  input  logic                wb_we_i,
  input  logic [3:0]          wb_adr_i,
  input  logic [31:0]         wb_dat_i,
  input  logic [3:0]          wb_sel_i,
  output logic                wb_ack_o,
  output logic [31:0]         wb_dat_o,
  input  logic [DNA_BITS-1:0] dna_i,
  input  logic                valid_i,
  input  logic                busy_i,
  output logic                restart_o
);

  logic        ack_q, ack_d;
  logic [31:0] dat_q, dat_d;
  logic        access;
  logic [1:0]  word;
  logic [95:0] dna_pad;
  logic [31:0] rdata;

  // Bits of the request that carry no meaning in this register map.
  logic unused_wb;
  assign unused_wb = ^{wb_adr_i[1:0], wb_dat_i[30:0], wb_sel_i[2:0]};

  // A new access is taken only while ack is low, so a held cyc/stb produces
  // alternating acks rather than a continuous one.
  assign access  = wb_cyc_i & wb_stb_i & ~ack_q;
  assign word    = wb_adr_i[3:2];
  assign dna_pad = 96'(dna_i);

  always_comb begin
    rdata = '0;
    case (word)
      DNA_W0:   rdata = dna_pad[31:0];
      DNA_W1:   rdata = dna_pad[63:32];
      DNA_W2:   rdata = dna_pad[95:64];
      DNA_CTRL: begin
        rdata[CTRL_VALID] = valid_i;
        rdata[CTRL_BUSY]  = busy_i;
      end
      default:  rdata = '0;
    endcase
  end

  assign restart_o = access & wb_we_i & (word == DNA_CTRL) & wb_sel_i[3] &
                     wb_dat_i[CTRL_RESTART];

  always_comb begin
    ack_d = access;
    dat_d = dat_q;
    if (access) begin
      dat_d = rdata;
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      ack_q <= 1'b0;
      dat_q <= '0;
    end else begin
      ack_q <= ack_d;
      dat_q <= dat_d;
    end
  end

  assign wb_ack_o = ack_q;
  assign wb_dat_o = dat_q;

endmodule

// File: rtl/surf_dna_sequencer.sv
// Autonomous readout sequencer for the DNA_PORTE2 device-DNA primitive.
// On reset (AUTO_START=1), a start_i pulse or a Wishbone restart write it
// pulses READ, then clocks SHIFT DNA_BITS times, capturing DOUT LSB-first
// into a holding register exposed on dna_o and over Wishbone.
// Ports:
//   wb_*          Wishbone slave (clock also drives the primitive CLK)
//   start_i       hardware restart pulse
//   dna_read_o    DNA_PORTE2 READ
//   dna_shift_o   DNA_PORTE2 SHIFT
//   dna_din_o     DNA_PORTE2 DIN (tied low)
//   dna_dout_i    DNA_PORTE2 DOUT
//   busy_o        readout in progress
//   valid_o       dna_o holds a complete DNA
//   dna_o         holding register
module surf_dna_sequencer
  import surf_id_pkg::*;
#(
  parameter int unsigned DNA_BITS   = DNA_BITS_DEFAULT,
  parameter bit          AUTO_START = 1'b1,
  parameter int unsigned CLK_DIV    = 1
) (
  input  logic                wb_clk_i,
  input  logic                wb_rst_i,
  input  logic                wb_cyc_i,
  input  logic                wb_stb_i,
  input  logic                wb_we_i,
  input  logic [3:0]          wb_adr_i,
  input  logic [31:0]         wb_dat_i,
  input  logic [3:0]          wb_sel_i,
  output logic                wb_ack_o,
  output logic                wb_err_o,
  output logic                wb_rty_o,
  output logic [31:0]         wb_dat_o,
  input  logic                start_i,
  output logic                dna_read_o,
  output logic                dna_shift_o,
  output logic                dna_din_o,
  input  logic                dna_dout_i,
  output logic                busy_o,
  output logic                valid_o,
  output logic [DNA_BITS-1:0] dna_o
);

  localparam int unsigned    DivW    = $clog2(CLK_DIV) + 1;
  localparam int unsigned    CntW    = $clog2(DNA_BITS) + 1;
  localparam logic [DivW-1:0] DivLast = DivW'(CLK_DIV - 1);
  localparam logic [CntW-1:0] CntLast = CntW'(DNA_BITS - 1);

  dna_state_t          state_q, state_d;
  logic [DivW-1:0]     div_q, div_d;
  logic [CntW-1:0]     bitcnt_q, bitcnt_d;
  logic [DNA_BITS-1:0] sreg_q, sreg_d;
  logic [DNA_BITS-1:0] dna_q, dna_d;
  logic                pend_q, pend_d;
  logic                restart;
  logic                step_last;
  logic                start_req;

  surf_dna_wb_regs #(
    .DNA_BITS (DNA_BITS)
  ) u_wb_regs (
    .wb_clk_i  (wb_clk_i),
    .wb_rst_i  (wb_rst_i),
    .wb_cyc_i  (wb_cyc_i),
    .wb_stb_i  (wb_stb_i),
    .wb_we_i   (wb_we_i),
    .wb_adr_i  (wb_adr_i),
    .wb_dat_i  (wb_dat_i),
    .wb_sel_i  (wb_sel_i),
    .wb_ack_o  (wb_ack_o),
    .wb_dat_o  (wb_dat_o),
    .dna_i     (dna_q),
    .valid_i   (valid_o),
    .busy_i    (busy_o),
    .restart_o (restart)
  );

  assign step_last = (div_q == DivLast);
  // All start sources merge here, so coincident requests yield one readout.
  assign start_req = start_i | pend_q | restart;

  always_comb begin
    state_d  = state_q;
    div_d    = div_q;
    bitcnt_d = bitcnt_q;
    sreg_d   = sreg_q;
    dna_d    = dna_q;
    pend_d   = pend_q;
    case (state_q)
      IDLE, DONE: begin
        if (start_req) begin
          state_d = READ;
          div_d   = '0;
          pend_d  = 1'b0;
        end
      end
      READ: begin
        if (step_last) begin
          state_d  = SHIFT;
          div_d    = '0;
          bitcnt_d = '0;
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      SHIFT: begin
        if (step_last) begin
          // DOUT already presents the next bit; capture it on the shift edge.
          sreg_d   = {dna_dout_i, sreg_q[DNA_BITS-1:1]};
          bitcnt_d = bitcnt_q + 1'b1;
          div_d    = '0;
          if (bitcnt_q == CntLast) begin
            state_d = DONE;
            dna_d   = sreg_d;
          end
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q  <= IDLE;
      div_q    <= '0;
      bitcnt_q <= '0;
      sreg_q   <= '0;
      dna_q    <= '0;
      pend_q   <= AUTO_START;
    end else begin
      state_q  <= state_d;
      div_q    <= div_d;
      bitcnt_q <= bitcnt_d;
      sreg_q   <= sreg_d;
      dna_q    <= dna_d;
      pend_q   <= pend_d;
    end
  end

  // Strobes decoded from registered state only; the states are exclusive so
  // READ and SHIFT can never be high together.
  assign dna_read_o  = (state_q == READ) & step_last;
  assign dna_shift_o = (state_q == SHIFT) & step_last;
  assign dna_din_o   = 1'b0;
  assign busy_o      = (state_q == READ) | (state_q == SHIFT);
  assign valid_o     = (state_q == DONE);
  assign dna_o       = dna_q;
  assign wb_err_o    = 1'b0;
  assign wb_rty_o    = 1'b0;

endmodule

// File: tb/tb_surf_dna_sequencer.sv
// Bench for surf_dna_sequencer: instance A (AUTO_START=1, CLK_DIV=1) and
// instance B (AUTO_START=0, CLK_DIV=4), each driven by a behavioural
// DNA_PORTE2 model. Expected WB read data and completed readouts go into
// queues that per-instance monitors pop and compare.
module tb_surf_dna_sequencer;

  localparam logic [95:0] DNA_A = 96'h0123_4567_89AB_CDEF_FEDC_BA98;
  localparam logic [95:0] DNA_B = 96'hA5A5_0F0F_1234_5678_DEAD_BEEF;

  typedef struct {
    int          id;
    logic [31:0] data;
    bit          chk;
  } wb_exp_t;

  typedef struct {
    int          id;
    logic [95:0] val;
    int          vcyc;
  } dna_exp_t;

  wb_exp_t  wb_q[$];
  dna_exp_t dna_q[$];

  int n_checks = 0;
  int n_fail   = 0;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic        rst       [2];
  logic        start     [2];
  logic        wb_cyc    [2];
  logic        wb_stb    [2];
  logic        wb_we     [2];
  logic [3:0]  wb_adr    [2];
  logic [31:0] wb_wdat   [2];
  logic [3:0]  wb_sel    [2];
  logic        wb_ack    [2];
  logic        wb_err    [2];
  logic        wb_rty    [2];
  logic [31:0] wb_rdat   [2];
  logic        dna_read  [2];
  logic        dna_shift [2];
  logic        dna_din   [2];
  logic        dna_dout  [2];
  logic        busy      [2];
  logic        valid     [2];
  logic [95:0] dna       [2];
  logic [95:0] model_sr  [2];

  int read_cnt      [2] = '{0, 0};
  int shift_cnt     [2] = '{0, 0};
  int last_read_cyc [2] = '{0, 0};
  int prev_ev_cyc   [2] = '{-1, -1};
  int space_err     [2] = '{0, 0};
  int overlap       [2] = '{0, 0};
  logic valid_prev  [2] = '{1'b0, 1'b0};

  surf_dna_sequencer #(
    .DNA_BITS   (96),
    .AUTO_START (1'b1),
    .CLK_DIV    (1)
  ) u_dut_a (
    .wb_clk_i    (clk),
    .wb_rst_i    (rst[0]),
    .wb_cyc_i    (wb_cyc[0]),
    .wb_stb_i    (wb_stb[0]),
    .wb_we_i     (wb_we[0]),
    .wb_adr_i    (wb_adr[0]),
    .wb_dat_i    (wb_wdat[0]),
    .wb_sel_i    (wb_sel[0]),
    .wb_ack_o    (wb_ack[0]),
    .wb_err_o    (wb_err[0]),
    .wb_rty_o    (wb_rty[0]),
    .wb_dat_o    (wb_rdat[0]),
    .start_i     (start[0]),
    .dna_read_o  (dna_read[0]),
    .dna_shift_o (dna_shift[0]),
    .dna_din_o   (dna_din[0]),
    .dna_dout_i  (dna_dout[0]),
    .busy_o      (busy[0]),
    .valid_o     (valid[0]),
    .dna_o       (dna[0])
  );

  surf_dna_sequencer #(
    .DNA_BITS   (96),
    .AUTO_START (1'b0),
    .CLK_DIV    (4)
  ) u_dut_b (
    .wb_clk_i    (clk),
    .wb_rst_i    (rst[1]),
    .wb_cyc_i    (wb_cyc[1]),
    .wb_stb_i    (wb_stb[1]),
    .wb_we_i     (wb_we[1]),
    .wb_adr_i    (wb_adr[1]),
    .wb_dat_i    (wb_wdat[1]),
    .wb_sel_i    (wb_sel[1]),
    .wb_ack_o    (wb_ack[1]),
    .wb_err_o    (wb_err[1]),
    .wb_rty_o    (wb_rty[1]),
    .wb_dat_o    (wb_rdat[1]),
    .start_i     (start[1]),
    .dna_read_o  (dna_read[1]),
    .dna_shift_o (dna_shift[1]),
    .dna_din_o   (dna_din[1]),
    .dna_dout_i  (dna_dout[1]),
    .busy_o      (busy[1]),
    .valid_o     (valid[1]),
    .dna_o       (dna[1])
  );

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name, input string act, input string exp);
    n_checks++;
    n_fail++;
    $display("FAIL %s: got %s expected %s", name, act, exp);
  endtask

  for (genvar g = 0; g < 2; g++) begin : g_chan
    localparam int Div = (g == 0) ? 1 : 4;
    wb_exp_t  we_e;
    dna_exp_t de_e;

    // Behavioural DNA_PORTE2: READ loads, SHIFT moves toward bit 0.
    always @(posedge clk) begin
      if (dna_read[g]) model_sr[g] <= (g == 0) ? DNA_A : DNA_B;
      else if (dna_shift[g]) model_sr[g] <= model_sr[g] >> 1;
    end
    assign dna_dout[g] = model_sr[g][0];

    always @(negedge clk) begin
      if (dna_read[g] === 1'b1 && dna_shift[g] === 1'b1) overlap[g]++;
      if (dna_read[g] === 1'b1) begin
        read_cnt[g]++;
        last_read_cyc[g] = cyc;
        prev_ev_cyc[g]   = cyc;
      end else if (dna_shift[g] === 1'b1) begin
        if (prev_ev_cyc[g] >= 0 && cyc - prev_ev_cyc[g] != Div) space_err[g]++;
        shift_cnt[g]++;
        prev_ev_cyc[g] = cyc;
      end
      if (wb_ack[g] === 1'b1) begin
        if (wb_q.size() == 0 || wb_q[0].id != g) begin
          fail_now("wb_ack", "unexpected ack", "no ack");
        end else begin
          we_e = wb_q.pop_front();
          if (we_e.chk) check("wb_rdata", 128'(wb_rdat[g]), 128'(we_e.data));
        end
      end
      if (valid[g] === 1'b1 && valid_prev[g] !== 1'b1) begin
        if (dna_q.size() == 0 || dna_q[0].id != g) begin
          fail_now("valid_rise", "unexpected readout completion", "none");
        end else begin
          de_e = dna_q.pop_front();
          check("dna_value", 128'(dna[g]), 128'(de_e.val));
          check("valid_cycle", 128'(cyc), 128'(de_e.vcyc));
        end
      end
      valid_prev[g] = valid[g];
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wb_xfer(input int d, input bit we, input logic [3:0] adr,
                         input logic [31:0] dat, input logic [31:0] exp, input bit chk,
                         output int c_issue);
    bit got;
    got = 1'b0;
    tick();
    wb_cyc[d]  = 1'b1;
    wb_stb[d]  = 1'b1;
    wb_we[d]   = we;
    wb_adr[d]  = adr;
    wb_wdat[d] = dat;
    wb_sel[d]  = 4'hF;
    c_issue    = cyc;
    wb_q.push_back('{d, exp, chk});
    for (int i = 0; i < 8 && !got; i++) begin
      @(negedge clk);
      if (wb_ack[d] === 1'b1) got = 1'b1;
    end
    if (!got) fail_now("wb_ack_timeout", "no ack in 8 cycles", "ack");
    tick();
    wb_cyc[d] = 1'b0;
    wb_stb[d] = 1'b0;
    wb_we[d]  = 1'b0;
  endtask

  task automatic wait_valid(input int d, input int budget);
    bit got;
    got = 1'b0;
    for (int i = 0; i < budget && !got; i++) begin
      @(negedge clk);
      if (valid[d] === 1'b1) got = 1'b1;
    end
    if (!got) fail_now("valid_timeout", "valid_o low", "valid_o high");
  endtask

  task automatic wait_shifts(input int d, input int base, input int n, input int budget);
    bit got;
    got = 1'b0;
    for (int i = 0; i < budget && !got; i++) begin
      @(negedge clk);
      if (shift_cnt[d] - base >= n) got = 1'b1;
    end
    if (!got) fail_now("shift_timeout", "too few shifts", "requested shift count");
  endtask

  task automatic check_reset(input int d, input string tag);
    check({tag, "_dna_o"}, 128'(dna[d]), 128'h0);
    check({tag, "_ctl"}, 128'({valid[d], busy[d], dna_read[d], dna_shift[d], wb_ack[d],
                                wb_err[d], wb_rty[d], dna_din[d]}), 128'h0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got no finish expected finish before timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0, rb, sb, ci;
    logic [5:0] ackpat;
    for (int d = 0; d < 2; d++) begin
      rst[d] = 1'b1; start[d] = 1'b0;
      wb_cyc[d] = 1'b0; wb_stb[d] = 1'b0; wb_we[d] = 1'b0;
      wb_adr[d] = 4'h0; wb_wdat[d] = 32'h0; wb_sel[d] = 4'h0;
    end
    repeat (3) tick();
    check_reset(0, "a_reset");
    check_reset(1, "b_reset");

    // A: auto-start after reset release.
    rst[0] = 1'b0;
    c0 = cyc; rb = read_cnt[0]; sb = shift_cnt[0];
    dna_q.push_back('{0, DNA_A, c0 + 98});
    wait_valid(0, 300);
    check("a_auto_reads", 128'(read_cnt[0] - rb), 128'd1);
    check("a_auto_read_cycle", 128'(last_read_cyc[0]), 128'(c0 + 1));
    check("a_auto_shifts", 128'(shift_cnt[0] - sb), 128'd96);
    wb_xfer(0, 1'b0, 4'h0, 32'h0, 32'hFEDC_BA98, 1'b1, ci);
    wb_xfer(0, 1'b0, 4'h4, 32'h0, 32'h89AB_CDEF, 1'b1, ci);
    wb_xfer(0, 1'b0, 4'h8, 32'h0, 32'h0123_4567, 1'b1, ci);

    // A: restart from DONE, then a restart during SHIFT that must be ignored.
    rb = read_cnt[0]; sb = shift_cnt[0];
    wb_xfer(0, 1'b1, 4'hC, 32'h8000_0000, 32'h0, 1'b0, ci);
    dna_q.push_back('{0, DNA_A, ci + 98});
    check("a_restart_status", 128'({valid[0], busy[0]}), 128'h1);
    repeat (10) tick();
    wb_xfer(0, 1'b1, 4'hC, 32'h8000_0000, 32'h0, 1'b0, ci);
    wait_valid(0, 300);
    check("a_restart_reads", 128'(read_cnt[0] - rb), 128'd1);
    check("a_restart_shifts", 128'(shift_cnt[0] - sb), 128'd96);

    // A: reset at shift 40, auto-start gives a fresh full readout.
    sb = shift_cnt[0];
    wb_xfer(0, 1'b1, 4'hC, 32'h8000_0000, 32'h0, 1'b0, ci);
    wait_shifts(0, sb, 40, 200);
    tick(); rst[0] = 1'b1;
    tick(); rst[0] = 1'b0;
    check_reset(0, "a_midrst");
    c0 = cyc; rb = read_cnt[0]; sb = shift_cnt[0];
    dna_q.push_back('{0, DNA_A, c0 + 98});
    wait_valid(0, 300);
    check("a_rerun_reads", 128'(read_cnt[0] - rb), 128'd1);
    check("a_rerun_read_cycle", 128'(last_read_cyc[0]), 128'(c0 + 1));
    check("a_rerun_shifts", 128'(shift_cnt[0] - sb), 128'd96);

    // A: cyc/stb held on the control word for six cycles.
    tick();
    wb_cyc[0] = 1'b1; wb_stb[0] = 1'b1; wb_we[0] = 1'b0;
    wb_adr[0] = 4'hC; wb_sel[0] = 4'hF;
    repeat (3) wb_q.push_back('{0, 32'h0000_0002, 1'b1});
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      ackpat[i] = wb_ack[0];
    end
    tick();
    wb_cyc[0] = 1'b0; wb_stb[0] = 1'b0;
    check("a_ack_pattern", 128'(ackpat), 128'(6'b101010));

    // B: no auto-start.
    rst[1] = 1'b0;
    rb = read_cnt[1];
    repeat (12) tick();
    check("b_idle_reads", 128'(read_cnt[1] - rb), 128'd0);
    check("b_idle_status", 128'({valid[1], busy[1]}), 128'h0);

    // B: start_i and WB restart together from IDLE.
    tick();
    start[1] = 1'b1;
    wb_cyc[1] = 1'b1; wb_stb[1] = 1'b1; wb_we[1] = 1'b1;
    wb_adr[1] = 4'hC; wb_wdat[1] = 32'h8000_0000; wb_sel[1] = 4'hF;
    ci = cyc; rb = read_cnt[1]; sb = shift_cnt[1];
    wb_q.push_back('{1, 32'h0, 1'b0});
    dna_q.push_back('{1, DNA_B, ci + 389});
    tick(); start[1] = 1'b0;
    tick(); wb_cyc[1] = 1'b0; wb_stb[1] = 1'b0; wb_we[1] = 1'b0;
    wait_valid(1, 600);
    check("b_dual_reads", 128'(read_cnt[1] - rb), 128'd1);
    check("b_dual_read_cycle", 128'(last_read_cyc[1]), 128'(ci + 4));
    check("b_dual_shifts", 128'(shift_cnt[1] - sb), 128'd96);

    // B: start_i pulse from DONE.
    tick();
    start[1] = 1'b1;
    ci = cyc; rb = read_cnt[1]; sb = shift_cnt[1];
    dna_q.push_back('{1, DNA_B, ci + 389});
    tick(); start[1] = 1'b0;
    wait_valid(1, 600);
    check("b_start_reads", 128'(read_cnt[1] - rb), 128'd1);
    check("b_start_read_cycle", 128'(last_read_cyc[1]), 128'(ci + 4));
    check("b_start_shifts", 128'(shift_cnt[1] - sb), 128'd96);
    wb_xfer(1, 1'b0, 4'h0, 32'h0, 32'hDEAD_BEEF, 1'b1, ci);
    wb_xfer(1, 1'b0, 4'h4, 32'h0, 32'h1234_5678, 1'b1, ci);
    wb_xfer(1, 1'b0, 4'h8, 32'h0, 32'hA5A5_0F0F, 1'b1, ci);

    // B: reset at shift 40 leaves it IDLE.
    sb = shift_cnt[1];
    tick(); start[1] = 1'b1;
    tick(); start[1] = 1'b0;
    wait_shifts(1, sb, 40, 400);
    tick(); rst[1] = 1'b1;
    tick(); rst[1] = 1'b0;
    check_reset(1, "b_midrst");
    rb = read_cnt[1];
    repeat (20) tick();
    check("b_midrst_reads", 128'(read_cnt[1] - rb), 128'd0);
    check("b_midrst_status", 128'({valid[1], busy[1]}), 128'h0);

    repeat (3) tick();
    check("wb_queue_empty", 128'(wb_q.size()), 128'd0);
    check("dna_queue_empty", 128'(dna_q.size()), 128'd0);
    check("a_overlap", 128'(overlap[0]), 128'd0);
    check("b_overlap", 128'(overlap[1]), 128'd0);
    check("a_spacing", 128'(space_err[0]), 128'd0);
    check("b_spacing", 128'(space_err[1]), 128'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
